sort_collector: RTL and testbench
=================================

# sort_collector

Receiving end of the sorter's serial output stream. Captures the N words the sorter emits while `data_valid` is high, deserialises them into a parallel register bank, checks that they arrive in the required order, and flags completion, ordering violations and surplus words. Sits between the sorter datapath output and the consumer or bench, which reads the parallel result once `done_o` is high.

## Interface
Parameters:
- `N`, 8: number of words per sort run (≥2).
- `W`, 8: word width in bits.
- `DESCENDING`, 1: 1 = each word must be ≤ its predecessor; 0 = each word must be ≥ its predecessor. Comparison is unsigned.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start_i`  in  1  arms a new run; clears the bank, count and flags.
- `data_i`  in  W  sorted word from the sorter.
- `data_valid_i`  in  1  `data_i` is valid this cycle. Treated as 0 whenever it is not exactly 1, so X/Z is ignored.
- `words_o`  out  N*W  captured words; word k occupies bits [k*W +: W], k = arrival index.
- `count_o`  out  $clog2(N+1)  number of words captured in the current run.
- `busy_o`  out  1  state is COLLECT.
- `done_o`  out  1  state is DONE; N words captured.
- `order_err_o`  out  1  sticky; an ordering violation occurred in this run.
- `overflow_o`  out  1  sticky; a valid word arrived while in DONE.

## Operation
- States: IDLE, COLLECT, DONE.
- Reset: state IDLE; `words_o`=0, `count_o`=0, `busy_o`=0, `done_o`=0, `order_err_o`=0, `overflow_o`=0.
- `start_i`=1 takes priority in every state:
  - next state COLLECT;
  - count, `words_o` and both flags are cleared;
  - a `data_valid_i` in the same cycle is discarded.
- IDLE: valid words are ignored. No flag changes.
- COLLECT, on valid:
  - `data_i` is written to slot `count_o`, then count increments;
  - for count ≥1, `data_i` is compared with slot count−1; a violation sets `order_err_o`;
  - equal words are legal.
- COLLECT, no valid: hold.
- COLLECT exit: when the Nth word is captured, the next state is DONE.
- DONE: outputs hold; a valid word sets `overflow_o` and is not stored. Only `start_i` or `rst` leave DONE.
- Mid-run reset: `rst` in any state returns all outputs to their reset values on the next edge. Reset overrides `start_i`.
- Gapped valid is legal: idle cycles between words do not affect capture.

## Timing
- Capture latency 1 cycle: a word valid at edge t is visible in `words_o` and `count_o` after edge t.
- `order_err_o` rises on the same edge that stores the offending word.
- `done_o` and `busy_o`=0 take effect on the edge that stores word N−1 (zero-based). `done_o` therefore rises in the same cycle that `count_o` reaches N.
- `overflow_o` rises 1 cycle after the surplus valid.
- Back-to-back: N consecutive valid cycles give `done_o` N cycles after the first valid edge.
- All outputs are registered; there is no combinational input-to-output path.

## Structure
- Shared sort package holds the collector state encoding (IDLE=2'b00, COLLECT=2'b01, DONE=2'b11, Gray-adjacent). The same package carries the default `N`/`W` constants so they match the sorter.
- A natural sub-module is `sort_order_check`: a combinational unsigned comparator (prev, curr, `DESCENDING`) → violation. The register bank, counter and FSM stay in `sort_collector`.

## Test plan
- Reset/idle: N=8, W=8. Assert `rst` for 2 cycles, then drive valid words with no start → all outputs remain 0 and the state stays IDLE.
- Nominal descending: `start_i`, then 8 back-to-back words 200,150,150,90,40,12,3,0 → `done_o`=1 exactly 8 cycles after the first valid. `words_o` slots 0..7 match the input order, `count_o`=8, `order_err_o`=0.
- Order violation: words 9,8,10,7,6,5,4,3 → `order_err_o` rises on the edge storing 10 and stays high. Capture still completes and `done_o`=1.
- Gaps and overflow: 8 valid words with 3 idle cycles between each, then 2 more valid words → `done_o` after the 8th word, and `overflow_o`=1 one cycle after the 9th. `words_o` is unchanged by the 9th and 10th words.
- Start priority and restart: after 4 words captured, assert `start_i` together with `data_valid_i` (data 77) → `count_o`=0, `words_o`=0, flags cleared, 77 not stored. A following full run completes normally.
- Mid-run reset and ascending mode: `DESCENDING`=0; feed 1,2,3, then assert `rst` → all outputs 0 and state IDLE. After `start_i`, feeding 5,5,6,7,8,9,10,11 → `order_err_o`=0 and `done_o`=1.

Source files
------------

// File: rtl/sort_collector_pkg.sv
// sort_collector_pkg: shared collector state encoding and default sorter sizing
package sort_collector_pkg;
    localparam int SORT_N = 8;
    localparam int SORT_W = 8;
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        COLLECT = 2'b01,
        DONE    = 2'b11
    } coll_state_t;
endpackage

// File: rtl/sort_order_check.sv
// sort_order_check: unsigned ordering comparator flagging a violation between consecutive words
module sort_order_check #(
    parameter int W = 8,
    parameter bit DESCENDING = 1'b1
) (
    input  logic [W-1:0] prev,
    input  logic [W-1:0] curr,
    output logic         violation
);
    assign violation = DESCENDING ? (curr > prev) : (curr < prev);
endmodule

// File: rtl/sort_collector.sv
// sort_collector: deserialises the sorter output stream into a word bank and checks its order
module sort_collector
    import sort_collector_pkg::*;
#(
    parameter int N = SORT_N,
    parameter int W = SORT_W,
    parameter bit DESCENDING = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_i,
    input  logic [W-1:0]           data_i,
    input  logic                   data_valid_i,
    output logic [N*W-1:0]         words_o,
    output logic [$clog2(N+1)-1:0] count_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   order_err_o,
    output logic                   overflow_o
);
    localparam int CW = $clog2(N+1);
    localparam int IW = $clog2(N);
    coll_state_t state, state_n;
    logic [N-1:0][W-1:0] bank;
    logic [CW-1:0] count;
    logic [IW-1:0] idx;
    logic valid, last, violation, order_err, overflow;
    assign valid = (data_valid_i === 1'b1);
    assign idx = count[IW-1:0];
    assign last = (count == CW'(N-1));
    sort_order_check #(.W(W), .DESCENDING(DESCENDING)) u_check (
        .prev     (bank[idx - IW'(1)]),
        .curr     (data_i),
        .violation(violation)
    );
    always_comb begin
        state_n = state;
        state_n = start_i ? COLLECT : (state == COLLECT && valid && last) ? DONE : state;
    end
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end
    always_ff @(posedge clk) begin
        if (rst || start_i) begin
            bank      <= '0;
            count     <= '0;
            order_err <= 1'b0;
            overflow  <= 1'b0;
        end else if (state == COLLECT && valid) begin
            bank[idx] <= data_i;
            count     <= count + CW'(1);
            if (count != '0 && violation) order_err <= 1'b1;
        end else if (state == DONE && valid) begin
            overflow <= 1'b1;
        end
    end
    assign words_o     = bank;
    assign count_o     = count;
    assign busy_o      = (state == COLLECT);
    assign done_o      = (state == DONE);
    assign order_err_o = order_err;
    assign overflow_o  = overflow;
endmodule

// File: tb/tb_sort_collector.sv
// tb_sort_collector: directed scoreboard bench for descending and ascending collectors
module tb_sort_collector;
    import sort_collector_pkg::*;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_d, rst_a, start, dv;
    logic [7:0] data;
    logic [63:0] words_d, words_a;
    logic [3:0] count_d, count_a;
    logic busy_d, done_d, err_d, ovf_d, busy_a, done_a, err_a, ovf_a;
    int checks = 0;
    int passed = 0;
    logic [7:0] sb[$];

    sort_collector #(.N(8), .W(8), .DESCENDING(1'b1)) d (
        .clk(clk), .rst(rst_d), .start_i(start), .data_i(data), .data_valid_i(dv),
        .words_o(words_d), .count_o(count_d), .busy_o(busy_d), .done_o(done_d),
        .order_err_o(err_d), .overflow_o(ovf_d)
    );
    sort_collector #(.N(8), .W(8), .DESCENDING(1'b0)) a (
        .clk(clk), .rst(rst_a), .start_i(start), .data_i(data), .data_valid_i(dv),
        .words_o(words_a), .count_o(count_a), .busy_o(busy_a), .done_o(done_a),
        .order_err_o(err_a), .overflow_o(ovf_a)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic word(input logic [7:0] v);
        data = v;
        dv = 1'b1;
        sb.push_back(v);
        step();
        dv = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic check_bank(input string tag, input logic [63:0] w);
        for (int k = 0; k < 8; k++) begin
            logic [7:0] e;
            e = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
            chk($sformatf("%s[%0d]", tag, k), w[k*8 +: 8], e);
        end
        sb.delete();
    endtask

    initial begin
        logic [7:0] nom[8] = '{200, 150, 150, 90, 40, 12, 3, 0};
        logic [7:0] bad[8] = '{9, 8, 10, 7, 6, 5, 4, 3};
        logic [7:0] asc[8] = '{5, 5, 6, 7, 8, 9, 10, 11};
        rst_d = 1'b1; rst_a = 1'b1; start = 1'b0; dv = 1'b0; data = '0;
        step();
        step();
        rst_d = 1'b0; rst_a = 1'b0;
        chk("reset_outs", {words_d, count_d, busy_d, done_d, err_d, ovf_d}, '0);
        chk("reset_state", d.state, IDLE);
        for (int i = 0; i < 3; i++) begin
            data = 8'(i + 50); dv = 1'b1; step();
        end
        dv = 1'bx; step();
        dv = 1'b0;
        chk("idle_outs", {words_d, count_d, busy_d, done_d, err_d, ovf_d}, '0);
        chk("idle_state", d.state, IDLE);

        do_start();
        chk("nom_busy", busy_d, 1'b1);
        for (int i = 0; i < 8; i++) begin
            word(nom[i]);
            if (i == 6) chk("nom_done_early", done_d, 1'b0);
        end
        chk("nom_done", done_d, 1'b1);
        chk("nom_busy_end", busy_d, 1'b0);
        chk("nom_count", count_d, 4'd8);
        chk("nom_err", err_d, 1'b0);
        check_bank("nom_bank", words_d);

        do_start();
        for (int i = 0; i < 8; i++) begin
            word(bad[i]);
            if (i == 1) chk("bad_err_pre", err_d, 1'b0);
            if (i == 2) chk("bad_err_rise", err_d, 1'b1);
        end
        chk("bad_err_sticky", err_d, 1'b1);
        chk("bad_done", done_d, 1'b1);
        check_bank("bad_bank", words_d);

        do_start();
        for (int i = 0; i < 8; i++) begin
            word(8'(100 - 10 * i));
            if (i == 6) chk("gap_done_early", done_d, 1'b0);
            if (i == 7) chk("gap_done", done_d, 1'b1);
            for (int g = 0; g < 3; g++) step();
        end
        chk("gap_ovf_pre", ovf_d, 1'b0);
        data = 8'd255; dv = 1'b1; step(); dv = 1'b0;
        chk("gap_ovf", ovf_d, 1'b1);
        data = 8'd254; dv = 1'b1; step(); dv = 1'b0;
        chk("gap_ovf_sticky", ovf_d, 1'b1);
        chk("gap_count", count_d, 4'd8);
        chk("gap_err", err_d, 1'b0);
        check_bank("gap_bank", words_d);

        do_start();
        for (int i = 0; i < 4; i++) word(8'(5 + i));
        sb.delete();
        chk("sp_count4", count_d, 4'd4);
        chk("sp_err_set", err_d, 1'b1);
        start = 1'b1; dv = 1'b1; data = 8'd77;
        step();
        start = 1'b0; dv = 1'b0;
        chk("sp_count0", count_d, 4'd0);
        chk("sp_words0", words_d, '0);
        chk("sp_flags", {err_d, ovf_d}, 2'b00);
        chk("sp_busy", busy_d, 1'b1);
        for (int i = 0; i < 8; i++) word(8'(80 - 10 * i));
        chk("sp_done", done_d, 1'b1);
        chk("sp_err", err_d, 1'b0);
        check_bank("sp_bank", words_a == words_a ? words_d : '0);

        do_start();
        for (int i = 1; i <= 3; i++) word(8'(i));
        sb.delete();
        chk("asc_count3", count_a, 4'd3);
        rst_a = 1'b1; start = 1'b1;
        step();
        rst_a = 1'b0; start = 1'b0;
        chk("asc_rst_outs", {words_a, count_a, busy_a, done_a, err_a, ovf_a}, '0);
        chk("asc_rst_state", a.state, IDLE);
        do_start();
        for (int i = 0; i < 8; i++) word(asc[i]);
        chk("asc_err", err_a, 1'b0);
        chk("asc_done", done_a, 1'b1);
        chk("asc_count", count_a, 4'd8);
        check_bank("asc_bank", words_a);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
